// File: rtl/load_align_unit.sv
// Load alignment unit: issues word-aligned reads for load requests, keeps the
// outstanding loads in an in-order circular buffer, captures the memory
// responses and returns the extracted, sign/zero-extended value to writeback.
//
// Handshakes: a transfer happens on a channel in a cycle where valid and ready
// are both high at the rising edge; valid and its payload stay stable until that
// transfer. The memory side has no ready: mem_req_valid is always accepted, and
// mem_rvalid cannot be stalled.
module load_align_unit #(
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [4:0]  req_rd,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        exc_valid,
    output logic [31:0] exc_addr,
    output logic        resp_err
);

    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);

    // Buffer pointers and occupancy
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] fill_q, fill_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    // Per-entry storage
    logic [DEPTH-1:0] filled_q;
    logic [1:0]       off_q  [DEPTH];
    logic [2:0]       f3_q   [DEPTH];
    logic [4:0]       rd_q   [DEPTH];
    logic [31:0]      data_q [DEPTH];

    logic        exc_valid_q;
    logic [31:0] exc_addr_q;
    logic        resp_err_q;

    logic req_illegal, req_misaligned;
    logic req_fire, fire_legal, fire_bad;
    logic buf_full, resp_accept, pop;

    logic [31:0] hd_data;
    logic [1:0]  hd_off;
    logic [2:0]  hd_f3;
    logic [7:0]  hd_byte;
    logic [15:0] hd_half;

    // Classify the incoming request by funct3 and low address bits
    always_comb begin
        req_illegal    = 1'b0;
        req_misaligned = 1'b0;
        case (req_funct3)
            3'b000, 3'b100: req_misaligned = 1'b0;
            3'b001, 3'b101: req_misaligned = req_addr[0];
            3'b010:         req_misaligned = |req_addr[1:0];
            default:        req_illegal    = 1'b1;
        endcase
    end

    // Handshake decode; a full buffer blocks requests even while popping
    always_comb begin
        buf_full      = (count_q == CNT_FULL);
        req_ready     = !buf_full;
        req_fire      = req_valid && req_ready;
        fire_legal    = req_fire && !req_illegal && !req_misaligned;
        fire_bad      = req_fire && (req_illegal || req_misaligned);
        mem_req_valid = fire_legal;
        mem_req_addr  = {req_addr[31:2], 2'b00};
        // fill==tail is ambiguous when full: the entry at fill tells the two apart
        resp_accept   = mem_rvalid && ((fill_q != tail_q) || (buf_full && !filled_q[fill_q]));
        wb_valid      = (count_q != '0) && filled_q[head_q];
        pop           = wb_valid && wb_ready;
    end

    // Next pointer and occupancy values
    always_comb begin
        head_d  = head_q;
        fill_d  = fill_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (fire_legal)  tail_d = tail_q + PTR_ONE;
        if (resp_accept) fill_d = fill_q + PTR_ONE;
        if (pop)         head_d = head_q + PTR_ONE;
        case ({fire_legal, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            fill_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            fill_q  <= fill_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage: allocate at tail, capture response data at fill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filled_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                off_q[i]  <= '0;
                f3_q[i]   <= '0;
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (fire_legal) begin
                off_q[tail_q]    <= req_addr[1:0];
                f3_q[tail_q]     <= req_funct3;
                rd_q[tail_q]     <= req_rd;
                filled_q[tail_q] <= 1'b0;
            end
            if (resp_accept) begin
                data_q[fill_q]   <= mem_rdata;
                filled_q[fill_q] <= 1'b1;
            end
        end
    end

    // Exception pulse, held faulting address and sticky stray-response flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exc_valid_q <= 1'b0;
            exc_addr_q  <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            exc_valid_q <= fire_bad;
            if (fire_bad) exc_addr_q <= req_addr;
            if (mem_rvalid && !resp_accept) resp_err_q <= 1'b1;
        end
    end

    // Extract and extend the addressed field of the head entry
    always_comb begin
        hd_data = data_q[head_q];
        hd_off  = off_q[head_q];
        hd_f3   = f3_q[head_q];
        hd_byte = hd_data[{hd_off, 3'b000} +: 8];
        hd_half = hd_off[1] ? hd_data[31:16] : hd_data[15:0];
        case (hd_f3)
            3'b000:  wb_data = {{24{hd_byte[7]}}, hd_byte};
            3'b100:  wb_data = {24'h000000, hd_byte};
            3'b001:  wb_data = {{16{hd_half[15]}}, hd_half};
            3'b101:  wb_data = {16'h0000, hd_half};
            default: wb_data = hd_data;
        endcase
        wb_rd = rd_q[head_q];
    end

    assign exc_valid = exc_valid_q;
    assign exc_addr  = exc_addr_q;
    assign resp_err  = resp_err_q;

endmodule
